// File: rtl/mux_2x1_stream_if.sv
// Handshake bundle for the 2-to-1 packet stream merger: two input streams,
// one registered output stream and the packet-lock status flag.
interface mux_2x1_stream_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] i0_data;
  logic             i0_valid;
  logic             i0_last;
  logic             i0_ready;
  logic [WIDTH-1:0] i1_data;
  logic             i1_valid;
  logic             i1_last;
  logic             i1_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_src;
  logic             out_ready;
  logic             busy;

  // Producer/consumer side: drives both input streams, accepts the output.
  modport master (
    output i0_data, i0_valid, i0_last,
    input  i0_ready,
    output i1_data, i1_valid, i1_last,
    input  i1_ready,
    input  out_data, out_valid, out_last, out_src,
    output out_ready,
    input  busy
  );

  // Merger side.
  modport slave (
    input  i0_data, i0_valid, i0_last,
    output i0_ready,
    input  i1_data, i1_valid, i1_last,
    output i1_ready,
    output out_data, out_valid, out_last, out_src,
    input  out_ready,
    output busy
  );
endinterface

// File: rtl/mux_2x1_stream.sv
// Two-input to one-output packet stream merger. Round-robin arbitration
// between packets; once the first beat of a multi-beat packet is accepted the
// source stays locked until its last beat, so packets never interleave.
// The output is a single register stage that advances whenever it is empty
// or being drained by the consumer.
module mux_2x1_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  mux_2x1_stream_if.slave  s
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rr;
  logic             w_rr_nxt;

  logic             w_load_en;
  logic             w_gnt;
  logic             w_i0_ready;
  logic             w_i1_ready;
  logic             w_sel_valid;
  logic             w_sel_last;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_acc;

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_out_src;

  // The output register may take a new beat when it is empty or being drained.
  assign w_load_en = !r_out_valid || s.out_ready;

  // Grant selection, ready generation and next-state/round-robin update.
  always_comb begin
    w_gnt       = r_rr;
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;

    case (r_state)
      IDLE: begin
        if (s.i0_valid && s.i1_valid) w_gnt = r_rr;
        else if (s.i0_valid)          w_gnt = 1'b0;
        else if (s.i1_valid)          w_gnt = 1'b1;
        else                          w_gnt = r_rr;
      end
      LOCK0:   w_gnt = 1'b0;
      LOCK1:   w_gnt = 1'b1;
      default: w_gnt = r_rr;
    endcase

    // Readies are held low while reset is asserted so nothing is taken then.
    w_i0_ready = !rst && w_load_en && !w_gnt;
    w_i1_ready = !rst && w_load_en &&  w_gnt;

    w_sel_valid = w_gnt ? s.i1_valid : s.i0_valid;
    w_sel_last  = w_gnt ? s.i1_last  : s.i0_last;
    w_sel_data  = w_gnt ? s.i1_data  : s.i0_data;
    w_acc       = w_sel_valid && (w_gnt ? w_i1_ready : w_i0_ready);

    if (w_acc) begin
      if (w_sel_last) begin
        w_state_nxt = IDLE;
        w_rr_nxt    = !w_gnt;
      end else begin
        w_state_nxt = w_gnt ? LOCK1 : LOCK0;
      end
    end
  end

  // Arbitration state: packet lock and round-robin preference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
    end
  end

  // Output stage: capture the accepted beat; on an empty load only drop valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_src   <= 1'b0;
    end else if (w_load_en) begin
      r_out_valid <= w_acc;
      if (w_acc) begin
        r_out_data <= w_sel_data;
        r_out_last <= w_sel_last;
        r_out_src  <= w_gnt;
      end
    end
  end

  assign s.i0_ready  = w_i0_ready;
  assign s.i1_ready  = w_i1_ready;
  assign s.out_data  = r_out_data;
  assign s.out_valid = r_out_valid;
  assign s.out_last  = r_out_last;
  assign s.out_src   = r_out_src;
  assign s.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mux_2x1_stream.sv
// Bench for mux_2x1_stream: directed steps for reset, alternation, packet
// lock, backpressure and reset mid-packet, then a random phase; every output
// beat is checked against per-source scoreboard queues.
module tb_mux_2x1_stream;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_2x1_stream_if #(.WIDTH(WIDTH)) bus ();

  mux_2x1_stream #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  beat_t exp_b;
  int    n_chk = 0;
  int    n_err = 0;
  int    n_in  = 0;
  int    n_out = 0;
  int    c0    = 0;
  int    c1    = 0;
  int    w;
  logic  acc0 = 1'b0;
  logic  acc1 = 1'b0;
  logic  pkt_act = 1'b0;
  logic  pkt_src = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: sample handshakes mid-cycle, pop output beats, push accepted inputs.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      pkt_act = 1'b0;
      acc0    = 1'b0;
      acc1    = 1'b0;
      n_in    = 0;
      n_out   = 0;
    end else begin
      acc0 = bus.i0_valid & bus.i0_ready;
      acc1 = bus.i1_valid & bus.i1_ready;
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (pkt_act) chk("no_interleave", bus.out_src, pkt_src);
        pkt_act = !bus.out_last;
        pkt_src = bus.out_src;
        chk("sb_nonempty", (bus.out_src ? q1.size() : q0.size()) != 0, 1);
        if ((bus.out_src ? q1.size() : q0.size()) != 0) begin
          exp_b = bus.out_src ? q1.pop_front() : q0.pop_front();
          chk("sb_data", bus.out_data, exp_b.data);
          chk("sb_last", bus.out_last, exp_b.last);
        end
      end
      if (acc0) begin q0.push_back({bus.i0_data, bus.i0_last}); n_in++; end
      if (acc1) begin q1.push_back({bus.i1_data, bus.i1_last}); n_in++; end
    end
  end

  initial begin
    rst = 1'b1;
    bus.i0_data = '0; bus.i0_valid = 1'b0; bus.i0_last = 1'b0;
    bus.i1_data = '0; bus.i1_valid = 1'b0; bus.i1_last = 1'b0;
    bus.out_ready = 1'b0;

    // Reset with random inputs
    repeat (4) begin
      @(posedge clk); #1;
      bus.i0_data = WIDTH'($urandom); bus.i0_valid = 1'($urandom); bus.i0_last = 1'($urandom);
      bus.i1_data = WIDTH'($urandom); bus.i1_valid = 1'($urandom); bus.i1_last = 1'($urandom);
      bus.out_ready = 1'($urandom);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data",  bus.out_data,  0);
      chk("rst_out_last",  bus.out_last,  0);
      chk("rst_out_src",   bus.out_src,   0);
      chk("rst_busy",      bus.busy,      0);
      chk("rst_i0_ready",  bus.i0_ready,  0);
      chk("rst_i1_ready",  bus.i1_ready,  0);
    end
    @(posedge clk); #1;
    bus.i0_valid = 1'b0; bus.i1_valid = 1'b0; bus.out_ready = 1'b1;
    rst = 1'b0;
    #1;
    chk("post_rst_valid", bus.out_valid, 0);
    chk("post_rst_busy",  bus.busy,      0);

    // Single-beat packets alternate starting with input 0
    bus.i0_data = 8'h11; bus.i0_last = 1'b1; bus.i0_valid = 1'b1;
    bus.i1_data = 8'h22; bus.i1_last = 1'b1; bus.i1_valid = 1'b1;
    #1;
    chk("rr0_i0_ready", bus.i0_ready, 1);
    chk("rr0_i1_ready", bus.i1_ready, 0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("alt_valid", bus.out_valid, 1);
      chk("alt_data",  bus.out_data,  (k % 2) ? 32'h22 : 32'h11);
      chk("alt_src",   bus.out_src,   k % 2);
    end
    bus.i0_valid = 1'b0; bus.i1_valid = 1'b0;
    @(posedge clk); #1;
    chk("alt_drain", bus.out_valid, 0);

    // Packet lock: 3-beat i0 packet while i1 waits
    bus.i0_data = 8'hA0; bus.i0_last = 1'b0; bus.i0_valid = 1'b1;
    bus.i1_data = 8'h33; bus.i1_last = 1'b1; bus.i1_valid = 1'b1;
    #1;
    chk("lock_b0_i0_ready", bus.i0_ready, 1);
    chk("lock_b0_i1_ready", bus.i1_ready, 0);
    @(posedge clk); #1;
    chk("lock_b0_out",  bus.out_data, 8'hA0);
    chk("lock_b0_busy", bus.busy, 1);
    bus.i0_data = 8'hA1; #1;
    chk("lock_b1_i1_ready", bus.i1_ready, 0);
    chk("lock_b1_i0_ready", bus.i0_ready, 1);
    @(posedge clk); #1;
    chk("lock_b1_out",  bus.out_data, 8'hA1);
    chk("lock_b1_busy", bus.busy, 1);
    bus.i0_data = 8'hA2; bus.i0_last = 1'b1; #1;
    chk("lock_b2_i1_ready", bus.i1_ready, 0);
    @(posedge clk); #1;
    chk("lock_b2_out",  bus.out_data, 8'hA2);
    chk("lock_b2_last", bus.out_last, 1);
    chk("lock_b2_busy", bus.busy, 0);
    bus.i0_valid = 1'b0; #1;
    chk("lock_rel_i1_ready", bus.i1_ready, 1);
    @(posedge clk); #1;
    chk("lock_i1_out", bus.out_data, 8'h33);
    chk("lock_i1_src", bus.out_src, 1);
    bus.i1_valid = 1'b0;
    @(posedge clk); #1;
    chk("lock_drain", bus.out_valid, 0);

    // Backpressure
    bus.i0_data = 8'h55; bus.i0_last = 1'b1; bus.i0_valid = 1'b1;
    bus.i1_data = 8'h66; bus.i1_last = 1'b1; bus.i1_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp_first", bus.out_data, 8'h55);
    bus.out_ready = 1'b0; #1;
    chk("bp_i0_ready", bus.i0_ready, 0);
    chk("bp_i1_ready", bus.i1_ready, 0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_hold_data",  bus.out_data,  8'h55);
      chk("bp_hold_src",   bus.out_src,   0);
      chk("bp_hold_i0_rdy", bus.i0_ready, 0);
      chk("bp_hold_i1_rdy", bus.i1_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_resume_data", bus.out_data, 8'h66);
    chk("bp_resume_src",  bus.out_src,  1);
    @(posedge clk); #1;
    chk("bp_next_data", bus.out_data, 8'h55);
    bus.i0_valid = 1'b0; bus.i1_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_drain", bus.out_valid, 0);

    // Reset in the middle of a 4-beat i1 packet
    bus.i1_data = 8'hB0; bus.i1_last = 1'b0; bus.i1_valid = 1'b1;
    @(posedge clk); #1;
    chk("mr_b0", bus.out_data, 8'hB0);
    bus.i1_data = 8'hB1;
    @(posedge clk); #1;
    chk("mr_b1",      bus.out_data, 8'hB1);
    chk("mr_b1_busy", bus.busy, 1);
    bus.i1_data = 8'hB2;
    rst = 1'b1; #1;
    chk("mr_out_valid", bus.out_valid, 0);
    chk("mr_busy",      bus.busy, 0);
    chk("mr_i1_ready",  bus.i1_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i0_data = 8'h77; bus.i0_last = 1'b1; bus.i0_valid = 1'b1;
    bus.i1_data = 8'h88; bus.i1_last = 1'b1; bus.i1_valid = 1'b1;
    #1;
    chk("mr_rr_i0_ready", bus.i0_ready, 1);
    chk("mr_rr_i1_ready", bus.i1_ready, 0);
    @(posedge clk); #1;
    chk("mr_win_data", bus.out_data, 8'h77);
    chk("mr_win_src",  bus.out_src,  0);
    bus.i0_valid = 1'b0; bus.i1_valid = 1'b0;
    @(posedge clk); #1;

    // Random traffic, valid held until accepted
    repeat (10000) begin
      @(posedge clk); #1;
      if (!bus.i0_valid || acc0) begin
        bus.i0_valid = ($urandom % 3) != 0;
        if (bus.i0_valid) begin
          c0++;
          bus.i0_data = {1'b0, 7'(c0)};
          bus.i0_last = ($urandom % 3) == 0;
        end
      end
      if (!bus.i1_valid || acc1) begin
        bus.i1_valid = ($urandom % 3) != 0;
        if (bus.i1_valid) begin
          c1++;
          bus.i1_data = {1'b1, 7'(c1)};
          bus.i1_last = ($urandom % 3) == 0;
        end
      end
      bus.out_ready = ($urandom % 4) != 0;
    end
    bus.i0_valid = 1'b0; bus.i1_valid = 1'b0; bus.out_ready = 1'b1;
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (bus.out_valid && w < 20);
    @(posedge clk); #1;
    chk("rand_drained",  bus.out_valid, 0);
    chk("rand_q0_empty", q0.size(), 0);
    chk("rand_q1_empty", q1.size(), 0);
    chk("rand_count",    n_out, n_in);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
